multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle main control FSM for the next revision of the MIPS-subset processor.
- Replaces the single-cycle combinational main control. Sequences one instruction over 3-5 cycles using the shared PC/IR/ALU/register-file datapath and one memory port.
- Memory is accessed through a ready handshake, so instruction and data memory can have variable latency.
- Drives datapath mux selects and write enables. ALU function comes from an ALU-select code plus the existing opcode/funct ALU control.

Parameters:
- OP_W, 6, opcode width
- ST_W, 4, state register width

Ports:
- CLK  input  1  system clock; all state changes on the rising edge
- masterReset  input  1  asynchronous, active-high reset
- opcode  input  6  instruction[31:26] from the IR (the IR holds it stable after FETCH)
- zero  input  1  ALU zero flag
- memReady  input  1  memory has completed the current read or write
- PCWrite, PCWriteCond, branchNe, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ExtOp  output  1 each  datapath controls
- ALUSrcB  output  2  ALU B select: 00=busB, 01=const 4, 10=extended imm, 11=sign-extended imm<<2
- PCSource  output  2  PC source: 00=ALU result, 01=ALUOut register, 10=jump target
- aluSel  output  2  ALU function: 00=add, 01=sub, 10=decode from opcode/funct
- state  output  4  current state (debug)
- halted  output  1  an illegal opcode was decoded

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, R_WB=8, I_EXEC=9, I_WB=10, BRANCH=11, JUMP=12, HALT=15. Codes 13 and 14 decode to HALT.
- Outputs are combinational from state, plus memReady in FETCH. Any output not listed for a state is 0.
- Reset: masterReset high forces state=IDLE immediately (asynchronous). Every output is 0 while in reset, including a MemWrite that was in progress. IDLE moves to FETCH on the next edge after reset releases.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, aluSel=00, PCSource=00. IRWrite and PCWrite equal memReady. Stay in FETCH while memReady=0; go to DECODE when memReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, aluSel=00, ExtOp=1 (precomputes the branch target). Next state by opcode:
  - 0 -> R_EXEC
  - 35 (lw) or 43 (sw) -> MEM_ADDR
  - 4 (beq) or 5 (bne) -> BRANCH
  - 2 (j) -> JUMP
  - 8, 10, 12, 13 (addi, slti, andi, ori) -> I_EXEC
  - any other opcode -> HALT
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, aluSel=00. lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Hold until memReady=1, then go to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Next: FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Hold until memReady=1, then go to FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, aluSel=10. Next: R_WB.
- R_WB: same ALU controls as R_EXEC, plus RegWrite=1, RegDst=1. Next: FETCH.
- I_EXEC and I_WB: ALUSrcA=1, ALUSrcB=10, aluSel=10. ExtOp=1 for opcodes 8 and 10; ExtOp=0 for 12 and 13 (zero-extend). I_WB adds RegWrite=1, RegDst=0. I_EXEC -> I_WB -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, aluSel=01, PCWriteCond=1, PCSource=01. branchNe=1 when opcode=5, else 0. Next: FETCH.
- JUMP: PCWrite=1, PCSource=10. Next: FETCH.
- HALT: halted=1, all other controls 0. Leave only on reset.
- Mutual exclusion: MemRead and MemWrite are never both 1. RegWrite and MemWrite are never both 1.
- memReady is ignored in every state except FETCH, MEM_READ and MEM_WRITE.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- Defined: adds two outputs:
  - cycleCount[31:0]: increments every cycle the state is not IDLE or HALT.
  - instrCount[31:0]: increments on each FETCH cycle with memReady=1.
  - Both reset asynchronously to 0 and wrap from 0xFFFFFFFF to 0.
- Undefined: neither port nor its counter logic exists.

Test Plan:
- Reset held then released, opcode=0, memReady=1 -> state sequence 0,1,2,7,8,1. RegWrite=1 and RegDst=1 only in state 8.
- lw (opcode=35) with memReady low for 3 cycles in MEM_READ -> state stays 4 for 3 cycles with MemRead=1, IorD=1, then 5 with RegWrite=1, MemtoReg=1. Total 8 cycles including FETCH.
- sw (opcode=43) with masterReset asserted mid-MEM_WRITE -> MemWrite drops to 0 with no clock edge; state=0.
- bne (opcode=5) -> BRANCH with PCWriteCond=1, branchNe=1, aluSel=01, PCSource=01. For beq (opcode=4), branchNe=0.
- andi (opcode=12) -> ExtOp=0 in states 9 and 10. Opcode 63 -> state 15, halted=1, stays there across 10 clock cycles.
- With MC_PERF_CNT_EN defined, run 3 R-type instructions with memReady=1 -> instrCount=3, cycleCount=12.

Source files
------------

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Multi-cycle main control FSM for the MIPS-subset datapath.
//            Sequences each instruction over 3-5 states on a shared
//            PC/IR/ALU/register-file datapath with one ready-handshaked
//            memory port.
// Options  : MC_PERF_CNT_EN adds cycleCount / instrCount outputs.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            CLK,
  input  logic            masterReset,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            memReady,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            branchNe,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            MemtoReg,
  output logic            RegDst,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic            ExtOp,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      PCSource,
  output logic [1:0]      aluSel,
  output logic [ST_W-1:0] state,
  output logic            halted
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]     cycleCount,
  output logic [31:0]     instrCount
`endif
);

  localparam logic [ST_W-1:0] S_IDLE      = ST_W'(0);
  localparam logic [ST_W-1:0] S_FETCH     = ST_W'(1);
  localparam logic [ST_W-1:0] S_DECODE    = ST_W'(2);
  localparam logic [ST_W-1:0] S_MEM_ADDR  = ST_W'(3);
  localparam logic [ST_W-1:0] S_MEM_READ  = ST_W'(4);
  localparam logic [ST_W-1:0] S_MEM_WB    = ST_W'(5);
  localparam logic [ST_W-1:0] S_MEM_WRITE = ST_W'(6);
  localparam logic [ST_W-1:0] S_R_EXEC    = ST_W'(7);
  localparam logic [ST_W-1:0] S_R_WB      = ST_W'(8);
  localparam logic [ST_W-1:0] S_I_EXEC    = ST_W'(9);
  localparam logic [ST_W-1:0] S_I_WB      = ST_W'(10);
  localparam logic [ST_W-1:0] S_BRANCH    = ST_W'(11);
  localparam logic [ST_W-1:0] S_JUMP      = ST_W'(12);
  localparam logic [ST_W-1:0] S_HALT      = ST_W'(15);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(0);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(13);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(35);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(43);

  logic [ST_W-1:0] state_q;
  logic [ST_W-1:0] state_d;

  // The zero flag is consumed by the datapath's branch gating, not here.
  logic unused_zero;
  assign unused_zero = zero;

  assign state = state_q;

  // State register; reset takes effect without waiting for a clock edge.
  always_ff @(posedge CLK or posedge masterReset) begin
    if (masterReset) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  // Next-state sequencing; memReady only matters in the memory-access states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = S_FETCH;
      S_FETCH:     if (memReady) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                           state_d = S_R_EXEC;
          OP_LW, OP_SW:                       state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
          OP_J:                               state_d = S_JUMP;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:  state_d = S_I_EXEC;
          default:                            state_d = S_HALT;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (memReady) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (memReady) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_I_EXEC:    state_d = S_I_WB;
      S_I_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      default:     state_d = S_HALT;  // HALT and the unused codes 13/14
    endcase
  end

  // Datapath controls decoded from the current state (Moore, except FETCH's
  // IR/PC write strobes which follow memReady so the IR loads on completion).
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    branchNe    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ExtOp       = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    aluSel      = 2'b00;
    halted      = 1'b0;
    case (state_q)
      S_IDLE: ;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = memReady;
        PCWrite = memReady;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ExtOp   = 1'b1;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtOp   = 1'b1;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_R_EXEC, S_R_WB: begin
        ALUSrcA  = 1'b1;
        aluSel   = 2'b10;
        RegWrite = (state_q == S_R_WB);
        RegDst   = (state_q == S_R_WB);
      end
      S_I_EXEC, S_I_WB: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        aluSel   = 2'b10;
        // andi/ori take a zero-extended immediate
        ExtOp    = (opcode == OP_ADDI) || (opcode == OP_SLTI);
        RegWrite = (state_q == S_I_WB);
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        aluSel      = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        branchNe    = (opcode == OP_BNE);
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: halted = 1'b1;
    endcase
  end

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] instr_cnt_q;
  logic        cnt_active;

  // Codes 0 (IDLE) and 13..15 (halt) are the only non-running states.
  assign cnt_active = (state_q != S_IDLE) && (state_q <= S_JUMP);

  // Performance counters; both wrap naturally at 32 bits.
  always_ff @(posedge CLK or posedge masterReset) begin
    if (masterReset) begin
      cycle_cnt_q <= 32'd0;
      instr_cnt_q <= 32'd0;
    end else begin
      if (cnt_active)                        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if ((state_q == S_FETCH) && memReady)  instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign cycleCount = cycle_cnt_q;
  assign instrCount = instr_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Self-checking bench for multicycle_control. Expected state paths
//            are built per instruction class; expected controls come from a
//            per-state table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  typedef struct packed {
    logic       PCWrite, PCWriteCond, branchNe, IorD, MemRead, MemWrite;
    logic       IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ExtOp;
    logic [1:0] ALUSrcB, PCSource, aluSel;
    logic       halted;
  } ctl_t;

  logic       CLK = 1'b0;
  logic       masterReset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       memReady = 1'b0;
  logic [3:0] state;
  ctl_t       got;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycleCount, instrCount;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 CLK = ~CLK;

  multicycle_control #(.OP_W(6), .ST_W(4)) dut (
    .CLK(CLK), .masterReset(masterReset), .opcode(opcode), .zero(zero),
    .memReady(memReady),
    .PCWrite(got.PCWrite), .PCWriteCond(got.PCWriteCond), .branchNe(got.branchNe),
    .IorD(got.IorD), .MemRead(got.MemRead), .MemWrite(got.MemWrite),
    .IRWrite(got.IRWrite), .MemtoReg(got.MemtoReg), .RegDst(got.RegDst),
    .RegWrite(got.RegWrite), .ALUSrcA(got.ALUSrcA), .ExtOp(got.ExtOp),
    .ALUSrcB(got.ALUSrcB), .PCSource(got.PCSource), .aluSel(got.aluSel),
    .state(state), .halted(got.halted)
`ifdef MC_PERF_CNT_EN
    , .cycleCount(cycleCount), .instrCount(instrCount)
`endif
  );

  // Control table: what each state must drive.
  function automatic ctl_t exp_ctl(int st, logic [5:0] op, logic rdy);
    ctl_t c;
    c = '0;
    case (st)
      1:  begin c.MemRead = 1; c.ALUSrcB = 2'b01; c.IRWrite = rdy; c.PCWrite = rdy; end
      2:  begin c.ALUSrcB = 2'b11; c.ExtOp = 1; end
      3:  begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; c.ExtOp = 1; end
      4:  begin c.MemRead = 1; c.IorD = 1; end
      5:  begin c.RegWrite = 1; c.MemtoReg = 1; end
      6:  begin c.MemWrite = 1; c.IorD = 1; end
      7:  begin c.ALUSrcA = 1; c.aluSel = 2'b10; end
      8:  begin c.ALUSrcA = 1; c.aluSel = 2'b10; c.RegWrite = 1; c.RegDst = 1; end
      9, 10: begin
        c.ALUSrcA = 1; c.ALUSrcB = 2'b10; c.aluSel = 2'b10;
        c.ExtOp = (op == 6'd8 || op == 6'd10);
        c.RegWrite = (st == 10);
      end
      11: begin
        c.ALUSrcA = 1; c.aluSel = 2'b01; c.PCWriteCond = 1; c.PCSource = 2'b01;
        c.branchNe = (op == 6'd5);
      end
      12: begin c.PCWrite = 1; c.PCSource = 2'b10; end
      15: c.halted = 1;
      default: ;
    endcase
    return c;
  endfunction

  // Check the current cycle against an expected state.
  task automatic check_cycle(string tag, int exp_st, logic [5:0] op, logic rdy);
    ctl_t e;
    e = exp_ctl(exp_st, op, rdy);
    n_checks++;
    if (state !== 4'(exp_st)) begin
      n_err++;
      $display("FAIL %s state: op=%0d got %0d expected %0d", tag, op, state, exp_st);
    end
    n_checks++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s controls: st=%0d op=%0d got %h expected %h", tag, exp_st, op, got, e);
    end
    n_checks++;
    if ((got.MemRead && got.MemWrite) || (got.RegWrite && got.MemWrite)) begin
      n_err++;
      $display("FAIL %s exclusion: got %h expected no MemWrite overlap", tag, got);
    end
  endtask

  // Run one instruction from FETCH. fw/mw = wait cycles with memReady low in
  // FETCH / memory state. stop>0 ends after that many checked cycles.
  task automatic run_instr(string tag, logic [5:0] op, int fw, int mw, int stop);
    int   sq[$];
    logic rq[$];
    repeat (fw) begin sq.push_back(1); rq.push_back(1'b0); end
    sq.push_back(1); rq.push_back(1'b1);
    sq.push_back(2); rq.push_back(1'($urandom_range(0, 1)));
    case (op)
      6'd0:  begin sq.push_back(7); rq.push_back(1'($urandom_range(0,1)));
                   sq.push_back(8); rq.push_back(1'($urandom_range(0,1))); end
      6'd35: begin sq.push_back(3); rq.push_back(1'($urandom_range(0,1)));
                   repeat (mw) begin sq.push_back(4); rq.push_back(1'b0); end
                   sq.push_back(4); rq.push_back(1'b1);
                   sq.push_back(5); rq.push_back(1'($urandom_range(0,1))); end
      6'd43: begin sq.push_back(3); rq.push_back(1'($urandom_range(0,1)));
                   repeat (mw) begin sq.push_back(6); rq.push_back(1'b0); end
                   sq.push_back(6); rq.push_back(1'b1); end
      6'd4, 6'd5: begin sq.push_back(11); rq.push_back(1'($urandom_range(0,1))); end
      6'd2:  begin sq.push_back(12); rq.push_back(1'($urandom_range(0,1))); end
      6'd8, 6'd10, 6'd12, 6'd13: begin
                   sq.push_back(9);  rq.push_back(1'($urandom_range(0,1)));
                   sq.push_back(10); rq.push_back(1'($urandom_range(0,1))); end
      default: begin sq.push_back(15); rq.push_back(1'($urandom_range(0,1))); end
    endcase
    opcode = op;
    for (int i = 0; i < sq.size(); i++) begin
      if (stop > 0 && i >= stop) break;
      @(negedge CLK);
      memReady = rq[i];
      zero     = 1'($urandom_range(0, 1));
      #1;
      check_cycle(tag, sq[i], op, rq[i]);
    end
  endtask

  // Confirm the FSM has returned to FETCH after an instruction.
  task automatic check_fetch(string tag);
    @(negedge CLK);
    memReady = 1'b0;
    #1;
    check_cycle(tag, 1, opcode, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    masterReset = 1'b1;
    memReady    = 1'b1;
    #1;
    check_cycle("reset", 0, opcode, 1'b1);
`ifdef MC_PERF_CNT_EN
    n_checks++;
    if (cycleCount !== 32'd0 || instrCount !== 32'd0) begin
      n_err++;
      $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cycleCount, instrCount);
    end
`endif
    @(negedge CLK);
    masterReset = 1'b0;
    memReady    = 1'b0;
    #1;
    check_cycle("idle", 0, opcode, 1'b0);
  endtask

  task automatic test_reset();
    opcode = 6'd0;
    do_reset();
    run_instr("rtype", 6'd0, 0, 0, 0);
    check_fetch("rtype_ret");
  endtask

  task automatic test_lw();
    do_reset();
    run_instr("lw", 6'd35, 0, 3, 0);
    check_fetch("lw_ret");
  endtask

  task automatic test_sw_reset();
    do_reset();
    run_instr("sw", 6'd43, 1, 5, 6);  // stops mid MEM_WRITE
    masterReset = 1'b1;
    #1;
    n_checks++;
    if (got.MemWrite !== 1'b0 || state !== 4'd0) begin
      n_err++;
      $display("FAIL sw_async_reset: MemWrite=%b state=%0d expected 0/0", got.MemWrite, state);
    end
    @(negedge CLK);
    masterReset = 1'b0;
  endtask

  task automatic test_branch();
    do_reset();
    run_instr("bne", 6'd5, 0, 0, 0);
    run_instr("beq", 6'd4, 2, 0, 0);
    run_instr("j",   6'd2, 0, 0, 0);
    check_fetch("br_ret");
  endtask

  task automatic test_itype();
    do_reset();
    run_instr("andi", 6'd12, 0, 0, 0);
    run_instr("ori",  6'd13, 0, 0, 0);
    run_instr("addi", 6'd8,  1, 0, 0);
    run_instr("slti", 6'd10, 0, 0, 0);
    check_fetch("i_ret");
  endtask

  task automatic test_halt(logic [5:0] op);
    do_reset();
    run_instr("halt", op, 0, 0, 0);
    repeat (10) begin
      @(negedge CLK);
      memReady = 1'($urandom_range(0, 1));
      #1;
      check_cycle("halt_hold", 15, op, memReady);
    end
  endtask

  task automatic test_random();
    logic [5:0] legal[10] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd8, 6'd10, 6'd12, 6'd13};
    logic [5:0] bad;
    do_reset();
    repeat (40) begin
      run_instr("rand", legal[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end
    check_fetch("rand_ret");
    do begin
      bad = 6'($urandom_range(0, 63));
    end while (bad inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd8, 6'd10, 6'd12, 6'd13});
    test_halt(bad);
  endtask

`ifdef MC_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    repeat (3) run_instr("perf", 6'd0, 0, 0, 0);
    check_fetch("perf_ret");
    n_checks++;
    if (instrCount !== 32'd3 || cycleCount !== 32'd12) begin
      n_err++;
      $display("FAIL perf_cnt: got instr=%0d cycle=%0d expected 3/12", instrCount, cycleCount);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lw();
    test_sw_reset();
    test_branch();
    test_itype();
    test_halt(6'd63);
    test_random();
`ifdef MC_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
